spi_master: RTL and testbench

- Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI master. It drives SCK/MOSI/SSEL toward the on-chip SPI slave and samples MISO.
- Sits between a byte-stream producer/consumer (valid/ready) and the SPI pins.
- Generates SCK by dividing clk.
- Holds SSEL low across multi-byte transactions until a byte tagged last has been shifted.

---
 rtl/spi_master.sv | 168 ++++++++++++++++
 tb/tb_spi_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) MSB-first 8-bit SPI master with a valid/ready byte stream.
// SSEL stays asserted across bytes until one tagged last has been shifted out.
module spi_master #(
  parameter int unsigned CLK_DIV  = 8,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4,
  parameter int unsigned CS_IDLE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SSEL
);

  localparam int unsigned CNT_W = 16;
  // The SCK low time before the first rise must also satisfy the half-period.
  localparam int unsigned LEAD = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(LEAD);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(CS_HOLD);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(CS_IDLE);

  typedef enum logic [2:0] {CSIDLE, IDLE, SETUP, XFER, GAP, HOLD} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_cnt, bit_nx;
  logic             sck_r, sck_nx;
  logic             mosi_r, mosi_nx;
  logic             ssel_r, ssel_nx;
  logic [7:0]       rx_data_r, rx_data_nx;
  logic             rx_valid_r, rx_valid_nx;
  logic             busy_r;
  logic [6:0]       tx_shift, tx_shift_nx;
  logic [7:0]       rx_shift, rx_shift_nx;
  logic             last_r, last_nx;
  logic             miso_q1, miso_q2;
  logic             cnt_done, accept;

  // Counters are loaded with a cycle count and expire on the cycle they read 1.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_nx      = bit_cnt;
    sck_nx      = sck_r;
    mosi_nx     = mosi_r;
    ssel_nx     = ssel_r;
    rx_data_nx  = rx_data_r;
    rx_valid_nx = 1'b0;
    tx_shift_nx = tx_shift;
    rx_shift_nx = rx_shift;
    last_nx     = last_r;
    tx_ready    = (state == IDLE) || (state == GAP);
    accept      = tx_valid && tx_ready;
    cnt_done    = (cnt <= CNT_W'(1));
    if (!cnt_done) cnt_nx = cnt - CNT_W'(1);

    case (state)
      CSIDLE: begin
        if (cnt_done) begin
          state_nx = IDLE;
          mosi_nx  = 1'b0;
        end
      end
      IDLE, GAP: begin
        if (accept) begin
          state_nx    = SETUP;
          ssel_nx     = 1'b0;
          mosi_nx     = tx_data[7];
          tx_shift_nx = tx_data[6:0];
          last_nx     = tx_last;
          cnt_nx      = (state == IDLE) ? LEAD_LD : DIV_LD;
        end
      end
      SETUP: begin
        if (cnt_done) begin
          state_nx    = XFER;
          sck_nx      = 1'b1;
          cnt_nx      = DIV_LD;
          rx_shift_nx = {rx_shift[6:0], miso_q2};
        end
      end
      XFER: begin
        if (cnt_done) begin
          cnt_nx = DIV_LD;
          if (!sck_r) begin
            sck_nx      = 1'b1;
            rx_shift_nx = {rx_shift[6:0], miso_q2};
          end else begin
            sck_nx = 1'b0;
            bit_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_nx  = rx_shift;
              rx_valid_nx = 1'b1;
              if (last_r) begin
                state_nx = HOLD;
                cnt_nx   = HOLD_LD;
              end else begin
                state_nx = GAP;
              end
            end else begin
              mosi_nx     = tx_shift[6];
              tx_shift_nx = {tx_shift[5:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_nx = CSIDLE;
          ssel_nx  = 1'b1;
          cnt_nx   = IDLE_LD;
        end
      end
      default: state_nx = CSIDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CSIDLE;
      cnt        <= IDLE_LD;
      bit_cnt    <= 3'd0;
      sck_r      <= 1'b0;
      mosi_r     <= 1'b0;
      ssel_r     <= 1'b1;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bit_cnt    <= bit_nx;
      sck_r      <= sck_nx;
      mosi_r     <= mosi_nx;
      ssel_r     <= ssel_nx;
      rx_data_r  <= rx_data_nx;
      rx_valid_r <= rx_valid_nx;
      busy_r     <= (state_nx != IDLE);
    end
  end

  // Shift registers and the MISO synchronizer carry no control meaning.
  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_nx;
    rx_shift <= rx_shift_nx;
    last_r   <= last_nx;
    miso_q1  <= MISO;
    miso_q2  <= miso_q1;
  end

  assign SCK      = sck_r;
  assign MOSI     = mosi_r;
  assign SSEL     = ssel_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: bus monitor plus mode-0 slave model, expectations from SPI framing rules.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int D = 8, CSS = 4, CSH = 4, CSI = 4;
  localparam int LEAD = (CSS > D) ? CSS : D;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0, tx_last = 1'b0;
  logic tx_ready, rx_valid, busy, SCK, MOSI, SSEL, MISO;
  logic [7:0] rx_data;

  int miso_mode = 0;  // 0 loopback, 1 slave model, 2 tied high, 3 tied low
  logic miso_slave = 1'b0;
  assign MISO = (miso_mode == 0) ? MOSI : (miso_mode == 1) ? miso_slave : (miso_mode == 2);

  spi_master #(.CLK_DIV(D), .CS_SETUP(CSS), .CS_HOLD(CSH), .CS_IDLE(CSI)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SSEL(SSEL));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int rise_q[$], rxv_q[$], sfall_q[$], srise_q[$], trdy_q[$];
  logic [7:0] rxd_q[$], mosi_q[$];
  int sck_hi_err = 0, mbits = 0;
  logic [7:0] mbyte = 8'h00;
  logic p_sck = 1'b0, p_ssel = 1'b1, p_trdy = 1'b0;
  logic [7:0] slave_resp [4];
  logic [1:0] s_byte = 2'd0;
  logic [2:0] s_bit = 3'd7;

  // Bus monitor and mode-0 slave, evaluated just after each rising clk edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (SCK && !p_sck) begin
      rise_q.push_back(cyc);
      if (SSEL) sck_hi_err++;
      mbyte = {mbyte[6:0], MOSI};
      mbits++;
      if (mbits == 8) begin mosi_q.push_back(mbyte); mbits = 0; end
    end
    if (!SCK && p_sck && !SSEL) begin
      if (s_bit == 3'd0) begin s_byte++; s_bit = 3'd7; end
      else s_bit--;
      miso_slave = slave_resp[s_byte][s_bit];
    end
    if (!SSEL && p_ssel) begin
      sfall_q.push_back(cyc);
      s_byte = 2'd0; s_bit = 3'd7;
      miso_slave = slave_resp[0][7];
    end
    if (SSEL && !p_ssel) srise_q.push_back(cyc);
    if (rx_valid) begin rxv_q.push_back(cyc); rxd_q.push_back(rx_data); end
    if (tx_ready && !p_trdy) trdy_q.push_back(cyc);
    p_sck = SCK; p_ssel = SSEL; p_trdy = tx_ready;
  end

  task automatic mon_clear();
    rise_q.delete(); rxv_q.delete(); sfall_q.delete(); srise_q.delete(); trdy_q.delete();
    rxd_q.delete(); mosi_q.delete();
    sck_hi_err = 0; mbits = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int acc);
    int w = 0;
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!tx_ready && w < 4000) begin @(negedge clk); w++; end
    acc = tx_ready ? cyc + 1 : -1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    tx_last = 1'($urandom);
  endtask

  task automatic wait_done(input int nss, output bit ok);
    int w = 0;
    @(negedge clk);
    while (!(srise_q.size() >= nss && !busy) && w < 6000) begin @(negedge clk); w++; end
    ok = (srise_q.size() >= nss) && !busy;
  endtask

  task automatic test_reset();
    int w = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (SSEL !== 1'b1) begin n_bad++; $display("FAIL rst_ssel got %b want 1", SSEL); end
    n_cmp++; if (SCK !== 1'b0) begin n_bad++; $display("FAIL rst_sck got %b want 0", SCK); end
    n_cmp++; if (MOSI !== 1'b0) begin n_bad++; $display("FAIL rst_mosi got %b want 0", MOSI); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL rst_tx_ready got %b want 0", tx_ready); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rst_rx_data got %h want 00", rx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_n = 1'b1;
    while (!tx_ready && w < 100) begin @(negedge clk); w++; end
    n_cmp++; if (!(tx_ready && w >= CSI)) begin n_bad++; $display("FAIL rst_csidle cycles got %0d want >= %0d", w, CSI); end
  endtask

  task automatic test_single();
    int a, bad;
    bit ok;
    miso_mode = 0;
    mon_clear();
    send(8'hA5, 1'b1, a);
    wait_done(1, ok);
    bad = 0;
    for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 2 * D) bad++;
    n_cmp++; if (!ok || a < 0) begin n_bad++; $display("FAIL single_done ok=%0d acc=%0d want completion", ok, a); end
    n_cmp++; if (rise_q.size() != 8) begin n_bad++; $display("FAIL single_rises got %0d want 8", rise_q.size()); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_period bad periods %0d want 0", bad); end
    n_cmp++; if (rise_q[0] - a != LEAD) begin n_bad++; $display("FAIL single_first_rise got %0d want %0d", rise_q[0] - a, LEAD); end
    n_cmp++; if (rxd_q.size() != 1 || rxd_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_rx n=%0d got %h want A5", rxd_q.size(), rxd_q[0]); end
    n_cmp++; if (rxv_q[0] - a != LEAD + 15 * D) begin n_bad++; $display("FAIL single_rxv_lat got %0d want %0d", rxv_q[0] - a, LEAD + 15 * D); end
    n_cmp++; if (mosi_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_mosi got %h want A5", mosi_q[0]); end
    n_cmp++; if (sfall_q.size() != 1 || sfall_q[0] != a) begin n_bad++; $display("FAIL single_ssel_fall n=%0d at %0d want at %0d", sfall_q.size(), sfall_q[0], a); end
    n_cmp++; if (srise_q.size() != 1 || srise_q[0] - rxv_q[0] != CSH) begin n_bad++; $display("FAIL single_ssel_hold got %0d want %0d", srise_q[0] - rxv_q[0], CSH); end
    n_cmp++; if (sck_hi_err != 0) begin n_bad++; $display("FAIL single_sck_ssel_hi got %0d want 0", sck_hi_err); end
  endtask

  task automatic test_two_byte();
    int a0, a1;
    bit ok;
    miso_mode = 1;
    slave_resp[0] = 8'($urandom); slave_resp[1] = 8'h04;
    slave_resp[2] = 8'($urandom); slave_resp[3] = 8'($urandom);
    mon_clear();
    send(8'h03, 1'b0, a0);
    send(8'h5A, 1'b1, a1);
    wait_done(1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL two_done got %0d want 1", ok); end
    n_cmp++; if (sfall_q.size() != 1 || srise_q.size() != 1) begin n_bad++; $display("FAIL two_ssel edges fall=%0d rise=%0d want 1/1", sfall_q.size(), srise_q.size()); end
    n_cmp++; if (rxd_q.size() != 2) begin n_bad++; $display("FAIL two_rxv_count got %0d want 2", rxd_q.size()); end
    n_cmp++; if (rxd_q[0] !== slave_resp[0]) begin n_bad++; $display("FAIL two_rx0 got %h want %h", rxd_q[0], slave_resp[0]); end
    n_cmp++; if (rxd_q[1] !== 8'h04) begin n_bad++; $display("FAIL two_rx1 got %h want 04", rxd_q[1]); end
    n_cmp++; if (mosi_q[0] !== 8'h03 || mosi_q[1] !== 8'h5A) begin n_bad++; $display("FAIL two_mosi got %h %h want 03 5A", mosi_q[0], mosi_q[1]); end
    n_cmp++; if (rise_q.size() != 16) begin n_bad++; $display("FAIL two_rises got %0d want 16", rise_q.size()); end
    n_cmp++; if (rise_q[8] - a1 != D) begin n_bad++; $display("FAIL two_gap_lead got %0d want %0d", rise_q[8] - a1, D); end
    n_cmp++; if (rxv_q[1] - a1 != D + 15 * D) begin n_bad++; $display("FAIL two_rxv1_lat got %0d want %0d", rxv_q[1] - a1, 16 * D); end
  endtask

  task automatic test_gap_stall();
    int a0, a1, w, viol;
    bit ok;
    logic [7:0] b0;
    miso_mode = 0;
    b0 = 8'($urandom);
    mon_clear();
    send(b0, 1'b0, a0);
    w = 0;
    while (rxd_q.size() < 1 && w < 4000) begin @(negedge clk); w++; end
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (SSEL !== 1'b0 || SCK !== 1'b0 || tx_ready !== 1'b1 || MOSI !== b0[0]) viol++;
    end
    send(8'hFF, 1'b1, a1);
    wait_done(1, ok);
    n_cmp++; if (viol != 0 || w >= 4000) begin n_bad++; $display("FAIL gap_hold violations %0d wait %0d want 0", viol, w); end
    n_cmp++; if (rxd_q[0] !== b0 || rxd_q[1] !== 8'hFF) begin n_bad++; $display("FAIL gap_rx got %h %h want %h FF", rxd_q[0], rxd_q[1], b0); end
    n_cmp++; if (!ok || sfall_q.size() != 1 || srise_q.size() != 1) begin n_bad++; $display("FAIL gap_ssel fall=%0d rise=%0d want 1/1", sfall_q.size(), srise_q.size()); end
    n_cmp++; if (mosi_q[1] !== 8'hFF || rise_q.size() != 16) begin n_bad++; $display("FAIL gap_byte2 mosi %h rises %0d want FF 16", mosi_q[1], rise_q.size()); end
  endtask

  task automatic test_miso_tied();
    int a;
    bit ok;
    logic [7:0] b;
    for (int m = 2; m <= 3; m++) begin
      miso_mode = m;
      b = 8'($urandom);
      repeat (4) @(negedge clk);
      mon_clear();
      send(b, 1'b1, a);
      wait_done(1, ok);
      n_cmp++; if (!ok || rxd_q.size() != 1 || rxd_q[0] !== ((m == 2) ? 8'hFF : 8'h00)) begin
        n_bad++; $display("FAIL tied_miso mode %0d got %h want %h", m, rxd_q[0], (m == 2) ? 8'hFF : 8'h00); end
      n_cmp++; if (mosi_q[0] !== b) begin n_bad++; $display("FAIL tied_mosi got %h want %h", mosi_q[0], b); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [4];
    int w;
    bit ok;
    miso_mode = 0;
    mon_clear();
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'($urandom);
      tx_data = b[i]; tx_last = 1'b1; tx_valid = 1'b1;
      w = 0;
      while (!tx_ready && w < 4000) begin @(negedge clk); w++; end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_done(4, ok);
    n_cmp++; if (!ok || sfall_q.size() != 4 || rxd_q.size() != 4) begin n_bad++; $display("FAIL b2b_count falls %0d rx %0d want 4/4", sfall_q.size(), rxd_q.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rxd_q[i] !== b[i]) begin n_bad++; $display("FAIL b2b_rx%0d got %h want %h", i, rxd_q[i], b[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (sfall_q[i+1] - srise_q[i] < CSI) begin n_bad++; $display("FAIL b2b_ssel_idle%0d got %0d want >= %0d", i, sfall_q[i+1] - srise_q[i], CSI); end
      n_cmp++; if (trdy_q[i] - srise_q[i] < CSI) begin n_bad++; $display("FAIL b2b_ready_csidle%0d got %0d want >= %0d", i, trdy_q[i] - srise_q[i], CSI); end
    end
  endtask

  task automatic test_reset_mid();
    int a, w, bad;
    bit ok;
    logic [7:0] b;
    miso_mode = 0;
    b = 8'($urandom);
    mon_clear();
    send(b, 1'b1, a);
    w = 0;
    while (rise_q.size() < 5 && w < 4000) begin @(negedge clk); w++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (SSEL !== 1'b1 || SCK !== 1'b0 || MOSI !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pins ssel %b sck %b mosi %b want 1 0 0", SSEL, SCK, MOSI); end
    n_cmp++; if (busy !== 1'b0 || tx_ready !== 1'b0 || rx_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctrl busy %b rdy %b rxv %b want 0 0 0", busy, tx_ready, rx_valid); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    while (!tx_ready && w < 100) begin @(negedge clk); w++; end
    n_cmp++; if (rxd_q.size() != 0) begin n_bad++; $display("FAIL mid_rst_rxv got %0d pulses want 0", rxd_q.size()); end
    b = 8'($urandom);
    mon_clear();
    send(b, 1'b1, a);
    wait_done(1, ok);
    bad = 0;
    for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 2 * D) bad++;
    n_cmp++; if (!ok || rxd_q.size() != 1 || rxd_q[0] !== b) begin n_bad++; $display("FAIL post_rst_rx got %h want %h", rxd_q[0], b); end
    n_cmp++; if (mosi_q[0] !== b || rise_q.size() != 8 || bad != 0) begin n_bad++; $display("FAIL post_rst_bits mosi %h rises %0d badper %0d want %h 8 0", mosi_q[0], rise_q.size(), bad, b); end
    n_cmp++; if (rise_q[0] - a != LEAD || rxv_q[0] - a != LEAD + 15 * D) begin n_bad++; $display("FAIL post_rst_lat rise %0d rxv %0d want %0d %0d", rise_q[0] - a, rxv_q[0] - a, LEAD, LEAD + 15 * D); end
  endtask

  initial begin
    slave_resp[0] = 8'h00; slave_resp[1] = 8'h00; slave_resp[2] = 8'h00; slave_resp[3] = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_two_byte();
    test_gap_stall();
    test_miso_tied();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
